// File: rtl/mem_monitor_pkg.sv
// Shared opcodes, response bytes, widths and FSM encoding for the memory monitor.
package mem_monitor_pkg;

  localparam int unsigned TIMER_W         = 24;
  localparam int unsigned CNT_W           = 9;
  localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

  localparam logic [7:0] OP_WRITE    = 8'h57;
  localparam logic [7:0] OP_READ     = 8'h52;
  localparam logic [7:0] OP_DUMP     = 8'h44;
  localparam logic [7:0] ACK_DEFAULT = 8'h06;
  localparam logic [7:0] NAK_DEFAULT = 8'h15;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_ARG  = 3'd2,
    WRITE    = 3'd3,
    RD_ADDR  = 3'd4,
    RD_WAIT  = 3'd5,
    SEND     = 3'd6
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ) || (b == OP_DUMP);
  endfunction

endpackage

// File: rtl/mem_monitor_ctrl.sv
// Byte-command interpreter (write / read / dump) driving the program port of a 256-byte RAM.
module mem_monitor_ctrl
  import mem_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [7:0]  ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0]  NAK_BYTE = NAK_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       prg_clock,
  output logic       prg_we,
  output logic [7:0] prg_MA,
  output logic [7:0] prg_WD,
  input  logic [7:0] prg_RD,
  output logic       busy
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  state_t             state;
  logic [7:0]         op;
  logic [7:0]         addr;
  logic [CNT_W-1:0]   remaining;
  logic [TIMER_W-1:0] timer;

  assign prg_clock = clock;

  // Command FSM; prg_WD doubles as the write-data latch, busy tracks state != IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      op        <= '0;
      addr      <= '0;
      remaining <= '0;
      timer     <= '0;
      prg_we    <= 1'b0;
      prg_MA    <= '0;
      prg_WD    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_valid) begin
            op   <= rx_data;
            busy <= 1'b1;
            if (is_opcode(rx_data)) begin
              state <= GET_ADDR;
            end else begin
              tx_data  <= NAK_BYTE;
              tx_valid <= 1'b1;
              state    <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            timer <= '0;
            addr  <= rx_data;
            if (op == OP_READ) begin
              prg_MA    <= rx_data;
              remaining <= CNT_W'(1);
              state     <= RD_ADDR;
            end else begin
              state <= GET_ARG;
            end
          end else if (timer == TIMER_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        GET_ARG: begin
          if (rx_valid) begin
            timer  <= '0;
            prg_MA <= addr;
            if (op == OP_WRITE) begin
              prg_WD <= rx_data;
              prg_we <= 1'b1;
              state  <= WRITE;
            end else begin
              // A count of zero requests the full 256-byte dump.
              remaining <= (rx_data == 8'd0) ? CNT_W'(256) : CNT_W'(rx_data);
              state     <= RD_ADDR;
            end
          end else if (timer == TIMER_LAST) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        WRITE: begin
          prg_we   <= 1'b0;
          tx_data  <= ACK_BYTE;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        RD_ADDR: state <= RD_WAIT;
        RD_WAIT: begin
          tx_data  <= prg_RD;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (op == OP_DUMP && remaining > CNT_W'(1)) begin
              addr      <= addr + 8'd1;
              prg_MA    <= addr + 8'd1;
              remaining <= remaining - CNT_W'(1);
              state     <= RD_ADDR;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          prg_we   <= 1'b0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_monitor_ctrl.sv
// Scoreboard bench for mem_monitor_ctrl: stimulus pushes expected tx bytes, a monitor pops on each accepted transfer.
module tb_mem_monitor_ctrl;

  localparam int unsigned TO = 64;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       prg_clock;
  logic       prg_we;
  logic [7:0] prg_MA;
  logic [7:0] prg_WD;
  logic [7:0] prg_RD = 8'h00;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         rx_count = 0;
  int         we_pulses = 0;
  logic       toggle_ready = 1'b0;
  logic       preload = 1'b1;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_q [$];

  mem_monitor_ctrl #(.TIMEOUT(TO)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .prg_clock(prg_clock),
    .prg_we   (prg_we),
    .prg_MA   (prg_MA),
    .prg_WD   (prg_WD),
    .prg_RD   (prg_RD),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Synchronous RAM model on the program port.
  always @(posedge prg_clock) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else begin
      if (prg_we) mem[prg_MA] <= prg_WD;
      prg_RD <= mem[prg_MA];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid & ready are seen here.
  always @(negedge clock) begin
    if (reset_n && tx_valid && tx_ready) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'(tx_data), 32'h1FF);
      end else begin
        chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (prg_we) we_pulses++;
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_ready = toggle_ready ? ~tx_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic sendb(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(name, 32'(n >= budget), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back(8'h06);
    sendb(8'h57);
    sendb(a);
    sendb(d);
    exp_mem[a] = d;
    wait_done("write_done", 50);
  endtask

  initial begin
    int base;
    int we0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    chk("rst_prg_we", 32'(prg_we), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_prg_MA", 32'(prg_MA), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    preload = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Write 57,3A,C5: single prg_we cycle, then ACK
    we0 = we_pulses;
    exp_q.push_back(8'h06);
    sendb(8'h57);
    sendb(8'h3A);
    chk("w_we_before", 32'(prg_we), 0);
    sendb(8'hC5);
    chk("w_we", 32'(prg_we), 1);
    chk("w_ma", 32'(prg_MA), 32'h3A);
    chk("w_wd", 32'(prg_WD), 32'hC5);
    chk("w_txv_early", 32'(tx_valid), 0);
    @(posedge clock);
    #1;
    chk("w_we_off", 32'(prg_we), 0);
    chk("w_txv", 32'(tx_valid), 1);
    exp_mem[8'h3A] = 8'hC5;
    wait_done("w_done", 50);
    chk("w_pulses", 32'(we_pulses - we0), 1);

    // Read 52,3A: tx_valid rises 3 cycles after the address strobe
    exp_q.push_back(8'hC5);
    sendb(8'h52);
    sendb(8'h3A);
    chk("r_ma", 32'(prg_MA), 32'h3A);
    chk("r_txv_n1", 32'(tx_valid), 0);
    @(posedge clock);
    #1;
    chk("r_txv_n2", 32'(tx_valid), 0);
    @(posedge clock);
    #1;
    chk("r_txv_n3", 32'(tx_valid), 1);
    wait_done("r_done", 50);

    // Dump across the FF->00 wrap with a stalling consumer
    do_write(8'hFE, 8'h11);
    do_write(8'hFF, 8'h22);
    do_write(8'h00, 8'h33);
    toggle_ready = 1'b1;
    base = rx_count;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    sendb(8'h44);
    sendb(8'hFE);
    sendb(8'h03);
    wait_done("d3_done", 200);
    chk("d3_count", 32'(rx_count - base), 3);

    // Dump count 0 means 256 bytes in address order
    base = rx_count;
    for (int j = 0; j < 256; j++) exp_q.push_back(exp_mem[j]);
    sendb(8'h44);
    sendb(8'h00);
    sendb(8'h00);
    wait_done("d256_done", 5000);
    chk("d256_count", 32'(rx_count - base), 256);
    chk("d256_busy", 32'(busy), 0);

    // Timeout mid-write: no write, no tx, then NAK on an unknown opcode
    toggle_ready = 1'b0;
    we0 = we_pulses;
    sendb(8'h57);
    sendb(8'h10);
    repeat (TO - 8) @(posedge clock);
    #1;
    chk("to_busy_mid", 32'(busy), 1);
    repeat (16) @(posedge clock);
    #1;
    chk("to_busy_after", 32'(busy), 0);
    chk("to_no_we", 32'(we_pulses - we0), 0);
    exp_q.push_back(8'h15);
    sendb(8'h7A);
    wait_done("nak_done", 50);
    exp_q.push_back(exp_mem[8'h10]);
    sendb(8'h52);
    sendb(8'h10);
    wait_done("to_mem_intact", 50);

    // Asynchronous reset in the middle of a dump
    toggle_ready = 1'b1;
    for (int j = 0; j < 256; j++) exp_q.push_back(exp_mem[j]);
    sendb(8'h44);
    sendb(8'h00);
    sendb(8'h00);
    repeat (40) @(posedge clock);
    #2;
    chk("mr_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_we", 32'(prg_we), 0);
    chk("mr_txv", 32'(tx_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    base = rx_count;
    repeat (4) @(posedge clock);
    #1;
    chk("mr_idle_busy", 32'(busy), 0);
    chk("mr_no_resend", 32'(rx_count - base), 0);
    toggle_ready = 1'b0;
    exp_q.push_back(8'hC5);
    sendb(8'h52);
    sendb(8'h3A);
    wait_done("mr_read_after", 50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
